// File: rtl/mul_accum_sequencer.sv
// Sequential shift-and-add multiplier with optional accumulate (MLA).
// Early termination: RUN ends once the remaining multiplier bits are all zero.
module mul_accum_sequencer #(
  parameter int unsigned WORD = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            accumulate_i,
  input  logic            set_flags_i,
  input  logic            clear_i,
  input  logic [WORD-1:0] operand_a_i,
  input  logic [WORD-1:0] operand_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [WORD-1:0] accumulator_o,
  output logic            update_flag_o,
  output logic [1:0]      nz_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WORD-1:0] a_q, a_d;
  logic [WORD-1:0] b_q, b_d;
  logic [WORD-1:0] partial_q, partial_d;
  logic [WORD-1:0] acc_q, acc_d;
  logic            flag_q, flag_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      partial_q <= '0;
      acc_q     <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      partial_q <= partial_d;
      acc_q     <= acc_d;
      flag_q    <= flag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    partial_d = partial_q;
    acc_d     = acc_q;
    flag_d    = flag_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d       = operand_a_i;
          b_d       = operand_b_i;
          flag_d    = set_flags_i;
          // clear_i alongside start only zeroes the base; the accumulator itself holds until completion
          partial_d = (accumulate_i && !clear_i) ? acc_q : '0;
          state_d   = RUN;
        end else if (clear_i) begin
          acc_d = '0;
        end
      end
      RUN: begin
        if (b_q != '0) begin
          if (b_q[0]) partial_d = partial_q + a_q;
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end else begin
          acc_d   = partial_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign update_flag_o = (state_q == DONE) && flag_q;
  assign accumulator_o = acc_q;
  assign nz_o          = {acc_q[WORD-1], (acc_q == '0)};

endmodule

// File: tb/tb_mul_accum_sequencer.sv
// Directed-vector bench for mul_accum_sequencer with hand-computed results and latencies.
module tb_mul_accum_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        accumulate = 1'b0;
  logic        set_flags = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, upd;
  logic [31:0] acc;
  logic [1:0]  nz;

  int n_vec = 0;
  int n_err = 0;

  mul_accum_sequencer #(.WORD(32)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .accumulate_i (accumulate),
    .set_flags_i  (set_flags),
    .clear_i      (clear),
    .operand_a_i  (op_a),
    .operand_b_i  (op_b),
    .busy_o       (busy),
    .done_o       (done),
    .accumulator_o(acc),
    .update_flag_o(upd),
    .nz_o         (nz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // lat counts rising edges from the start-sampling edge (as 1) up to the edge that raises done_o.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic acc_en,
                        input logic sf, input logic clr, input logic noise,
                        input int exp_lat, input logic [31:0] exp_acc,
                        input logic [1:0] exp_nz, input logic exp_upd);
    logic [31:0] acc0;
    int lat;
    @(negedge clk);
    acc0 = acc;
    op_a = a; op_b = b; accumulate = acc_en; set_flags = sf; clear = clr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0; accumulate = 1'b0; set_flags = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      check("busy_run", {31'b0, busy}, 32'd1);
      check("acc_hold", acc, acc0);
      if (noise) begin
        start = 1'b1;
        clear = lat[0];
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("done", {31'b0, done}, 32'd1);
    check("upd_flag", {31'b0, upd}, {31'b0, exp_upd});
    check("acc", acc, exp_acc);
    check("nz", {30'b0, nz}, {30'b0, exp_nz});
    @(posedge clk); #1;
    check("done_gone", {31'b0, done}, 32'd0);
    check("busy_idle", {31'b0, busy}, 32'd0);
    check("upd_gone", {31'b0, upd}, 32'd0);
    start = 1'b0; clear = 1'b0;
    if (noise) begin
      @(posedge clk); #1;
      check("no_restart", {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_acc", acc, 32'd0);
    check("rst_nz", {30'b0, nz}, 32'd1);
    @(negedge clk); reset = 1'b0;

    run_op(32'd3, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5, 32'd15, 2'b00, 1'b1);
    run_op(32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 32'd0, 2'b01, 1'b0);
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 32'hFFFFFFFF, 2'b10, 1'b0);
    run_op(32'd2, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0, 34, 32'hFFFFFFFF, 2'b10, 1'b1);
    run_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 1'b1, 5, 32'd42, 2'b00, 1'b0);
    run_op(32'd100, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 32'd100, 2'b00, 1'b0);
    run_op(32'd4, 32'd4, 1'b1, 1'b0, 1'b1, 1'b0, 5, 32'd16, 2'b00, 1'b0);

    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    check("clear_acc", acc, 32'd0);
    check("clear_nz", {30'b0, nz}, 32'd1);
    check("clear_busy", {31'b0, busy}, 32'd0);

    run_op(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5, 32'd25, 2'b00, 1'b0);

    // Abort during the third RUN cycle of 9*0xFF.
    @(negedge clk);
    op_a = 32'd9; op_b = 32'hFF; set_flags = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; set_flags = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    check("pre_rst_acc", acc, 32'd25);
    reset = 1'b1; #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_acc", acc, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_upd", {31'b0, upd}, 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("post_rst_done", {31'b0, done}, 32'd0);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
    end

    run_op(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4, 32'd6, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
